prei_rc_qp_ctrl: RTL

- Parametrised CTU-level QP generator that sits between the pre-intra mode-decision engine and the CABAC/encoder core.
- Successor to the single-ROI rate control: supports NUM_ROI prioritised ROI regions, each with its own signed delta QP.
- Keeps a running bit-budget error from the actual bits CABAC reports, and accumulates per-frame 64x64 mode-decision cost.
- Start/done handshake per CTU; fixed latency.

---
 rtl/prei_rc_qp_ctrl_pkg.sv | 33 +++
 rtl/prei_rc_qp_ctrl_if.sv | 30 +++
 rtl/prei_rc_qp_ctrl_roi_match.sv | 27 ++
 rtl/prei_rc_qp_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/prei_rc_qp_ctrl_pkg.sv
// Shared constants for the CTU-level QP generator: FSM encodings, RC deltas, ROI field widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package prei_rc_qp_ctrl_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_CALC  = 3'd2;
  localparam logic [2:0] ST_CLAMP = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Budget-driven QP deltas (8-bit signed to match the QP arithmetic width)
  localparam logic signed [7:0] RC_DQP_P2 = 8'sd2;
  localparam logic signed [7:0] RC_DQP_P1 = 8'sd1;
  localparam logic signed [7:0] RC_DQP_Z  = 8'sd0;
  localparam logic signed [7:0] RC_DQP_M1 = -8'sd1;
  localparam logic signed [7:0] RC_DQP_M2 = -8'sd2;

  // L1/L2 thresholds are programmed in units of 256 bits
  localparam int THR_SHIFT = 8;

  // ROI register field widths
  localparam int ROI_X_W   = 7;
  localparam int ROI_Y_W   = 7;
  localparam int ROI_W_W   = 7;
  localparam int ROI_H_W   = 6;
  localparam int ROI_DQP_W = 6;

  // Minimum compare width: rx+w (7b+7b) always fits in 8 bits, so no wrap
  localparam int ROI_CMP_W = 8;

endpackage

// File: rtl/prei_rc_qp_ctrl_if.sv
// CTU request/response bundle between mode decision, the QP generator and the encoder core.
// Latency: n/a (wires only).
// Backpressure: none; start is a pulse, done is a pulse, busy tells the master when starts are dropped.
interface prei_rc_qp_ctrl_if #(
  parameter int PIC_X_WIDTH = 8,
  parameter int PIC_Y_WIDTH = 8,
  parameter int COST_WIDTH  = 28,
  parameter int BIT_WIDTH   = 16
);
  logic                   rc_start_i;
  logic [PIC_X_WIDTH-1:0] rc_ctu_x_i;
  logic [PIC_Y_WIDTH-1:0] rc_ctu_y_i;
  logic [COST_WIDTH-1:0]  modebest64_i;
  logic                   bits_vld_i;
  logic [BIT_WIDTH-1:0]   actual_bitnum_i;
  logic [5:0]             rc_qp_o;
  logic                   rc_done_o;
  logic                   rc_busy_o;
  logic [31:0]            mod64_sum_o;

  modport master (
    output rc_start_i, rc_ctu_x_i, rc_ctu_y_i, modebest64_i, bits_vld_i, actual_bitnum_i,
    input  rc_qp_o, rc_done_o, rc_busy_o, mod64_sum_o
  );

  modport slave (
    input  rc_start_i, rc_ctu_x_i, rc_ctu_y_i, modebest64_i, bits_vld_i, actual_bitnum_i,
    output rc_qp_o, rc_done_o, rc_busy_o, mod64_sum_o
  );
endinterface

// File: rtl/prei_rc_qp_ctrl_roi_match.sv
// Single ROI region hit test: (x,y) inside [rx,rx+w) x [ry,ry+h), region disabled when w==0.
// Latency: combinational.
// Backpressure: none.
module prei_roi_match
  import prei_rc_qp_ctrl_pkg::*;
#(
  parameter int CMP_W = ROI_CMP_W
) (
  input  logic [CMP_W-1:0]   x,
  input  logic [CMP_W-1:0]   y,
  input  logic [ROI_X_W-1:0] rx,
  input  logic [ROI_Y_W-1:0] ry,
  input  logic [ROI_W_W-1:0] w,
  input  logic [ROI_H_W-1:0] h,
  output logic               hit
);
  logic [CMP_W-1:0] x_lo, x_hi, y_lo, y_hi;

  // Region bounds widened so rx+w / ry+h can never wrap
  always_comb begin
    x_lo = CMP_W'(rx);
    y_lo = CMP_W'(ry);
    x_hi = CMP_W'(rx) + CMP_W'(w);
    y_hi = CMP_W'(ry) + CMP_W'(h);
    hit  = (w != '0) && (x >= x_lo) && (x < x_hi) && (y >= y_lo) && (y < y_hi);
  end
endmodule

// File: rtl/prei_rc_qp_ctrl.sv
// CTU QP generator: frame QP + budget-error delta + first-matching ROI delta, clamped to [min,max].
// Latency: rc_done_o fires NUM_ROI+3 cycles after an accepted rc_start_i.
// Backpressure: rc_start_i is dropped while busy; bits_vld_i is accepted every cycle.
module prei_rc_qp_ctrl
  import prei_rc_qp_ctrl_pkg::*;
#(
  parameter int PIC_X_WIDTH = 8,
  parameter int PIC_Y_WIDTH = 8,
  parameter int NUM_ROI     = 4,
  parameter int COST_WIDTH  = 28,
  parameter int BIT_WIDTH   = 16,
  parameter int ERR_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           rstn,
  prei_rc_qp_ctrl_if.slave               rc,
  input  logic [BIT_WIDTH-1:0]           reg_target_bits_i,
  input  logic                           reg_lcu_rc_en,
  input  logic [9:0]                     reg_L1_frame_byte,
  input  logic [9:0]                     reg_L2_frame_byte,
  input  logic [5:0]                     reg_initial_qp,
  input  logic [5:0]                     reg_max_qp,
  input  logic [5:0]                     reg_min_qp,
  input  logic [NUM_ROI*ROI_X_W-1:0]     reg_roi_x_i,
  input  logic [NUM_ROI*ROI_Y_W-1:0]     reg_roi_y_i,
  input  logic [NUM_ROI*ROI_W_W-1:0]     reg_roi_w_i,
  input  logic [NUM_ROI*ROI_H_W-1:0]     reg_roi_h_i,
  input  logic [NUM_ROI*ROI_DQP_W-1:0]   reg_roi_dqp_i,
  input  logic                           reg_roi_enable
);
  localparam int IW    = (NUM_ROI > 1) ? $clog2(NUM_ROI) : 1;
  localparam int XY_W  = (PIC_X_WIDTH > PIC_Y_WIDTH) ? PIC_X_WIDTH : PIC_Y_WIDTH;
  localparam int CMP_W = (XY_W > ROI_CMP_W) ? XY_W : ROI_CMP_W;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ROI - 1);

  logic [2:0]                   state;
  logic [IW-1:0]                scan_idx;
  logic [PIC_X_WIDTH-1:0]       x_lat;
  logic [PIC_Y_WIDTH-1:0]       y_lat;
  logic                         roi_found;
  logic [ROI_DQP_W-1:0]         roi_dqp;
  logic signed [ERR_WIDTH-1:0]  err;
  logic signed [7:0]            qp_calc;
  logic [5:0]                   qp_q;
  logic                         done_q, busy_q;
  logic [31:0]                  sum_q;

  logic start_acc, frame_start, roi_hit;
  int   sel;

  assign start_acc   = rc.rc_start_i && (state == ST_IDLE || state == ST_DONE);
  assign frame_start = start_acc && (rc.rc_ctu_x_i == '0) && (rc.rc_ctu_y_i == '0);
  assign sel         = int'(scan_idx);

  prei_roi_match #(.CMP_W(CMP_W)) u_roi_match (
    .x   (CMP_W'(x_lat)),
    .y   (CMP_W'(y_lat)),
    .rx  (reg_roi_x_i[sel*ROI_X_W +: ROI_X_W]),
    .ry  (reg_roi_y_i[sel*ROI_Y_W +: ROI_Y_W]),
    .w   (reg_roi_w_i[sel*ROI_W_W +: ROI_W_W]),
    .h   (reg_roi_h_i[sel*ROI_H_W +: ROI_H_W]),
    .hit (roi_hit)
  );

  // Saturating add of (actual - target) into the signed budget error
  logic signed [BIT_WIDTH:0] bit_diff;
  logic signed [ERR_WIDTH:0] err_sum;
  logic signed [ERR_WIDTH-1:0] err_next;
  always_comb begin
    bit_diff = $signed({1'b0, rc.actual_bitnum_i}) - $signed({1'b0, reg_target_bits_i});
    err_sum  = (ERR_WIDTH+1)'(err) + (ERR_WIDTH+1)'(bit_diff);
    if (err_sum[ERR_WIDTH] != err_sum[ERR_WIDTH-1])
      err_next = err_sum[ERR_WIDTH] ? {1'b1, {(ERR_WIDTH-1){1'b0}}} : {1'b0, {(ERR_WIDTH-1){1'b1}}};
    else
      err_next = err_sum[ERR_WIDTH-1:0];
  end

  // Budget delta from the error thresholds, plus ROI delta, on the frame QP
  logic signed [ERR_WIDTH:0] err_x, thr1, thr2;
  logic signed [7:0] rc_delta, roi_delta, qp_sum;
  always_comb begin
    err_x = (ERR_WIDTH+1)'(err);
    thr1  = $signed((ERR_WIDTH+1)'(reg_L1_frame_byte) << THR_SHIFT);
    thr2  = $signed((ERR_WIDTH+1)'(reg_L2_frame_byte) << THR_SHIFT);
    rc_delta = RC_DQP_Z;
    if (reg_lcu_rc_en) begin
      if (err_x >= thr2)       rc_delta = RC_DQP_P2;
      else if (err_x >= thr1)  rc_delta = RC_DQP_P1;
      else if (err_x <= -thr2) rc_delta = RC_DQP_M2;
      else if (err_x <= -thr1) rc_delta = RC_DQP_M1;
    end
    roi_delta = (reg_roi_enable && roi_found) ? 8'(signed'(roi_dqp)) : 8'sd0;
    qp_sum    = $signed({2'b00, reg_initial_qp}) + rc_delta + roi_delta;
  end

  // Lower clamp first (negative counts as below min), then upper clamp wins
  logic signed [7:0] qp_lo;
  logic [5:0] qp_clamped;
  always_comb begin
    if (qp_calc[7] || (qp_calc < $signed({2'b00, reg_min_qp})))
      qp_lo = $signed({2'b00, reg_min_qp});
    else
      qp_lo = qp_calc;
    if (qp_lo > $signed({2'b00, reg_max_qp}))
      qp_clamped = reg_max_qp;
    else
      qp_clamped = qp_lo[5:0];
  end

  // CTU FSM: latch request, scan regions, compute, clamp, publish
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      scan_idx  <= '0;
      x_lat     <= '0;
      y_lat     <= '0;
      roi_found <= 1'b0;
      roi_dqp   <= '0;
      qp_calc   <= '0;
      qp_q      <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (roi_hit && !roi_found) begin
            roi_found <= 1'b1;
            roi_dqp   <= reg_roi_dqp_i[sel*ROI_DQP_W +: ROI_DQP_W];
          end
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == LAST_IDX) state <= ST_CALC;
        end
        ST_CALC: begin
          qp_calc <= qp_sum;
          state   <= ST_CLAMP;
        end
        ST_CLAMP: begin
          qp_q   <= qp_clamped;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
      if (start_acc) begin
        state     <= ST_SCAN;
        scan_idx  <= '0;
        x_lat     <= rc.rc_ctu_x_i;
        y_lat     <= rc.rc_ctu_y_i;
        roi_found <= 1'b0;
        busy_q    <= 1'b1;
      end
    end
  end

  // Budget error: frame start clears it and drops a coincident strobe from the old frame
  always_ff @(posedge clk) begin
    if (!rstn)            err <= '0;
    else if (frame_start) err <= '0;
    else if (rc.bits_vld_i) err <= err_next;
  end

  // Frame cost sum: reload on frame start, otherwise wrap-around accumulate
  always_ff @(posedge clk) begin
    if (!rstn)            sum_q <= '0;
    else if (frame_start) sum_q <= 32'(rc.modebest64_i);
    else if (start_acc)   sum_q <= sum_q + 32'(rc.modebest64_i);
  end

  assign rc.rc_qp_o     = qp_q;
  assign rc.rc_done_o   = done_q;
  assign rc.rc_busy_o   = busy_q;
  assign rc.mod64_sum_o = sum_q;
endmodule
